// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the I/D-cache to main-memory arbiter.
package cache_mem_pkg;

  localparam int unsigned WordsPerBlock = 8;
  localparam int unsigned MemLatency    = 4;
  localparam int unsigned AddrW         = 16;
  localparam int unsigned DataW         = 16;

  localparam logic OwnI = 1'b0;
  localparam logic OwnD = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StFillI,
    StFillD,
    StWriteD,
    StDrain
  } arb_state_t;

endpackage

// File: rtl/arb_burst_counter.sv
// Issue/return counters for one burst: caps outstanding reads and flags completion.
module arb_burst_counter #(
  parameter int unsigned Words   = 8,
  parameter int unsigned Latency = 4,
  localparam int unsigned CntW   = $clog2(Words) + 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic issue_i,
  input  logic ret_i,
  output logic can_issue_o,
  output logic done_o,
  output logic drained_o
);

  logic [CntW-1:0] iss_q, iss_d;
  logic [CntW-1:0] ret_q, ret_d;
  logic [CntW-1:0] outst;
  logic [CntW-1:0] ret_nxt;
  logic            ret_inc;

  // A return with nothing outstanding is dropped so the count can never pass the issue count.
  assign ret_inc     = ret_i && (ret_q != iss_q);
  assign outst       = iss_q - ret_q;
  assign ret_nxt     = ret_q + CntW'(ret_inc);
  assign can_issue_o = (iss_q < CntW'(Words)) && (outst < CntW'(Latency));
  assign done_o      = (ret_nxt == CntW'(Words));
  assign drained_o   = (ret_nxt == iss_q);

  always_comb begin
    iss_d = iss_q;
    ret_d = ret_q;
    if (clr_i) begin
      iss_d = '0;
      ret_d = '0;
    end else begin
      if (issue_i && can_issue_o) iss_d = iss_q + CntW'(1);
      ret_d = ret_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_q <= '0;
      ret_q <= '0;
    end else begin
      iss_q <= iss_d;
      ret_q <= ret_d;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Grants the shared memory port to the I- or D-cache for a whole fill or one write.
// Define ARB_RR_EN for round-robin arbitration; otherwise the D-cache has fixed priority.
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int unsigned AddrWidth = AddrW,
  parameter int unsigned DataWidth = DataW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 icache_req_i,
  input  logic [AddrWidth-1:0] icache_addr_i,
  output logic                 icache_grant_o,
  output logic                 icache_data_valid_o,
  input  logic                 dcache_req_i,
  input  logic                 dcache_wr_i,
  input  logic [AddrWidth-1:0] dcache_addr_i,
  input  logic [DataWidth-1:0] dcache_wdata_i,
  output logic                 dcache_grant_o,
  output logic                 dcache_data_valid_o,
  output logic                 mem_enable_o,
  output logic                 mem_wr_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic                 mem_data_valid_i,
  input  logic [DataWidth-1:0] mem_data_in_i,
  output logic [DataWidth-1:0] fill_data_o
);

  arb_state_t state_q, state_d;
  logic       pick_d;
  logic       cnt_clr, cnt_issue, cnt_ret;
  logic       can_issue, done, drained;
  logic       own_req;

  assign fill_data_o = mem_data_in_i;

`ifdef ARB_RR_EN
  logic last_owner_q, last_owner_d;

  assign pick_d = dcache_req_i && (!icache_req_i || (last_owner_q == OwnI));

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == StIdle && (icache_req_i || dcache_req_i)) begin
      last_owner_d = pick_d ? OwnD : OwnI;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_owner_q <= OwnI;
    else       last_owner_q <= last_owner_d;
  end
`else
  assign pick_d = dcache_req_i;
`endif

  arb_burst_counter #(
    .Words   (WordsPerBlock),
    .Latency (MemLatency)
  ) u_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (cnt_clr),
    .issue_i     (cnt_issue),
    .ret_i       (cnt_ret),
    .can_issue_o (can_issue),
    .done_o      (done),
    .drained_o   (drained)
  );

  always_comb begin
    state_d             = state_q;
    cnt_clr             = 1'b0;
    cnt_issue           = 1'b0;
    cnt_ret             = 1'b0;
    own_req             = 1'b0;
    icache_grant_o      = 1'b0;
    dcache_grant_o      = 1'b0;
    icache_data_valid_o = 1'b0;
    dcache_data_valid_o = 1'b0;
    mem_enable_o        = 1'b0;
    mem_wr_o            = 1'b0;
    mem_addr_o          = '0;
    mem_wdata_o         = '0;

    case (state_q)
      StIdle: begin
        cnt_clr = 1'b1;
        if (pick_d)            state_d = dcache_wr_i ? StWriteD : StFillD;
        else if (icache_req_i) state_d = StFillI;
      end

      StFillI, StFillD: begin
        own_req = (state_q == StFillD) ? dcache_req_i : icache_req_i;
        cnt_ret = mem_data_valid_i;
        if (own_req) begin
          cnt_issue    = 1'b1;
          mem_enable_o = can_issue;
          if (state_q == StFillD) begin
            dcache_grant_o      = 1'b1;
            dcache_data_valid_o = mem_data_valid_i;
            if (can_issue) mem_addr_o = dcache_addr_i;
          end else begin
            icache_grant_o      = 1'b1;
            icache_data_valid_o = mem_data_valid_i;
            if (can_issue) mem_addr_o = icache_addr_i;
          end
          if (done) begin
            state_d = StIdle;
            cnt_clr = 1'b1;
          end
        end else if (drained) begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end else begin
          // Owner abandoned the burst: swallow the reads still in flight.
          state_d = StDrain;
        end
      end

      StWriteD: begin
        dcache_grant_o = 1'b1;
        mem_enable_o   = 1'b1;
        mem_wr_o       = 1'b1;
        mem_addr_o     = dcache_addr_i;
        mem_wdata_o    = dcache_wdata_i;
        state_d        = StIdle;
      end

      StDrain: begin
        cnt_ret = mem_data_valid_i;
        if (drained) begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a 4-cycle pipelined memory model.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_req, dcache_req, dcache_wr;
  logic [15:0] icache_addr, dcache_addr, dcache_wdata;
  logic        icache_grant, icache_data_valid, dcache_grant, dcache_data_valid;
  logic        mem_enable, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_wdata, mem_data_in, fill_data;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .icache_req_i        (icache_req),
    .icache_addr_i       (icache_addr),
    .icache_grant_o      (icache_grant),
    .icache_data_valid_o (icache_data_valid),
    .dcache_req_i        (dcache_req),
    .dcache_wr_i         (dcache_wr),
    .dcache_addr_i       (dcache_addr),
    .dcache_wdata_i      (dcache_wdata),
    .dcache_grant_o      (dcache_grant),
    .dcache_data_valid_o (dcache_data_valid),
    .mem_enable_o        (mem_enable),
    .mem_wr_o            (mem_wr),
    .mem_addr_o          (mem_addr),
    .mem_wdata_o         (mem_wdata),
    .mem_data_valid_i    (mem_data_valid),
    .mem_data_in_i       (mem_data_in),
    .fill_data_o         (fill_data)
  );

  // Memory model: a read strobed in cycle k returns in cycle k+4 with data addr ^ 0x5A5A.
  logic [3:0]  pv = '0;
  logic [15:0] pa [4];
  logic        model_en, stray;

  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_enable && !mem_wr};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end

  assign mem_data_valid = (model_en & pv[3]) | stray;
  assign mem_data_in    = pa[3] ^ 16'h5A5A;

  // Running event counts; the directed sequence compares deltas between snapshots.
  int          cyc = 0;
  int          n_rd = 0, n_badaddr = 0, n_iv = 0, n_dv = 0, n_mv = 0, n_baddata = 0;
  int          last_iv_cyc = 0;
  logic [15:0] exp_addr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_enable && !mem_wr) begin
      n_rd <= n_rd + 1;
      if (mem_addr !== exp_addr) n_badaddr <= n_badaddr + 1;
    end
    if (icache_data_valid) begin
      n_iv        <= n_iv + 1;
      last_iv_cyc <= cyc;
    end
    if (dcache_data_valid) n_dv <= n_dv + 1;
    if (mem_data_valid) n_mv <= n_mv + 1;
    if ((icache_data_valid || dcache_data_valid) && fill_data !== (exp_addr ^ 16'h5A5A)) begin
      n_baddata <= n_baddata + 1;
    end
  end

  int tests = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the owner's grant to drop; returns at the negedge where it is low.
  task automatic wait_drop(input bit is_d, input string tag);
    int n;
    bit g;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      g = is_d ? dcache_grant : icache_grant;
    end while (g && n < 80);
    chk(tag, {31'd0, g}, 32'd0);
  endtask

  int s_rd, s_iv, s_dv, s_bad, s_bd, s_mv, drop_cyc, cnt, n;
  bit first_d;

  initial begin
    rst = 1'b1; icache_req = 1'b0; dcache_req = 1'b0; dcache_wr = 1'b0;
    icache_addr = '0; dcache_addr = '0; dcache_wdata = '0;
    model_en = 1'b1; stray = 1'b0; exp_addr = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {26'd0, icache_grant, dcache_grant, mem_enable, mem_wr,
                     icache_data_valid, dcache_data_valid}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);

    // I-cache fill alone
    tick();
    icache_req = 1'b1; icache_addr = 16'h0100; exp_addr = 16'h0100;
    s_rd = n_rd; s_iv = n_iv; s_dv = n_dv; s_bad = n_badaddr; s_bd = n_baddata;
    @(negedge clk);
    chk("i_grant_c0", {31'd0, icache_grant}, 32'd0);
    @(negedge clk);
    chk("i_grant_c1", {29'd0, icache_grant, mem_enable, mem_wr}, 32'b110);
    chk("i_addr_c1", {16'd0, mem_addr}, 32'h0100);
    wait_drop(1'b0, "i_fill_done");
    drop_cyc = cyc;
    icache_req = 1'b0;
    tick();
    chk("i_rd_cnt", n_rd - s_rd, 8);
    chk("i_valid_cnt", n_iv - s_iv, 8);
    chk("i_no_dvalid", n_dv - s_dv, 0);
    chk("i_addr_bad", n_badaddr - s_bad, 0);
    chk("i_data_bad", n_baddata - s_bd, 0);
    chk("i_drop_lat", drop_cyc - last_iv_cyc, 1);

    // D-cache write-through
    dcache_req = 1'b1; dcache_wr = 1'b1; dcache_addr = 16'h1234; dcache_wdata = 16'hBEEF;
    @(negedge clk);
    chk("wr_c0", {31'd0, dcache_grant}, 32'd0);
    @(negedge clk);
    chk("wr_strobes", {28'd0, dcache_grant, icache_grant, mem_enable, mem_wr}, 32'b1011);
    chk("wr_addr", {16'd0, mem_addr}, 32'h1234);
    chk("wr_data", {16'd0, mem_wdata}, 32'hBEEF);
    dcache_req = 1'b0; dcache_wr = 1'b0;
    @(negedge clk);
    chk("wr_idle", {29'd0, dcache_grant, mem_enable, mem_wr}, 32'd0);

    // Simultaneous fills; last owner is now the D-cache
`ifdef ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    tick();
    icache_req = 1'b1; icache_addr = 16'h0200;
    dcache_req = 1'b1; dcache_wr = 1'b0; dcache_addr = 16'h0300;
    exp_addr = first_d ? 16'h0300 : 16'h0200;
    s_rd = n_rd; s_iv = n_iv; s_dv = n_dv; s_bad = n_badaddr; s_bd = n_baddata;
    @(negedge clk);
    chk("sim_c0", {30'd0, icache_grant, dcache_grant}, 32'd0);
    @(negedge clk);
    chk("sim_first", {30'd0, icache_grant, dcache_grant}, first_d ? 32'b01 : 32'b10);
    wait_drop(first_d, "sim_first_done");
    if (first_d) dcache_req = 1'b0;
    else         icache_req = 1'b0;
    exp_addr = first_d ? 16'h0200 : 16'h0300;
    chk("sim_first_rd", n_rd - s_rd, 8);
    chk("sim_first_v", first_d ? n_dv - s_dv : n_iv - s_iv, 8);
    chk("sim_first_other_v", first_d ? n_iv - s_iv : n_dv - s_dv, 0);
    s_rd = n_rd; s_iv = n_iv; s_dv = n_dv;
    @(negedge clk);
    chk("sim_second", {30'd0, icache_grant, dcache_grant}, first_d ? 32'b10 : 32'b01);
    wait_drop(!first_d, "sim_second_done");
    icache_req = 1'b0; dcache_req = 1'b0;
    tick();
    chk("sim_second_v", first_d ? n_iv - s_iv : n_dv - s_dv, 8);
    chk("sim_second_rd", n_rd - s_rd, 8);
    chk("sim_addr_bad", n_badaddr - s_bad, 0);
    chk("sim_data_bad", n_baddata - s_bd, 0);

    // Abandoned burst: 3 issues, 1 return, then 2 swallowed returns in DRAIN
    model_en = 1'b0;
    icache_req = 1'b1; icache_addr = 16'h0400; exp_addr = 16'h0400;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) stray = 1'b1;
      @(negedge clk);
      chk("dr_issue", {31'd0, mem_enable}, 32'd1);
    end
    chk("dr_fwd1", {31'd0, icache_data_valid}, 32'd1);
    tick();
    stray = 1'b0; icache_req = 1'b0;
    @(negedge clk);
    chk("dr_stop", {29'd0, icache_grant, mem_enable, icache_data_valid}, 32'd0);
    tick();
    stray = 1'b1;
    dcache_req = 1'b1; dcache_wr = 1'b1; dcache_addr = 16'h0042; dcache_wdata = 16'h1111;
    @(negedge clk);
    chk("dr_swallow1", {28'd0, icache_data_valid, dcache_data_valid, icache_grant, dcache_grant},
        32'd0);
    tick();
    @(negedge clk);
    chk("dr_swallow2", {28'd0, icache_data_valid, dcache_data_valid, icache_grant, dcache_grant},
        32'd0);
    tick();
    stray = 1'b0;
    @(negedge clk);
    chk("dr_idle", {30'd0, dcache_grant, mem_enable}, 32'd0);
    tick();
    @(negedge clk);
    chk("dr_then_wr", {30'd0, dcache_grant, mem_wr}, 32'b11);
    dcache_req = 1'b0; dcache_wr = 1'b0;
    tick();
    model_en = 1'b1;

    // Reset mid-fill after 5 issues
    icache_req = 1'b1; icache_addr = 16'h0500; exp_addr = 16'h0500;
    cnt = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_enable) cnt++;
    end while (cnt < 5 && n < 40);
    chk("rst_mid_issue5", cnt, 5);
    tick();
    rst = 1'b1;
    tick();
    icache_req = 1'b0;
    s_iv = n_iv; s_dv = n_dv; s_mv = n_mv;
    @(negedge clk);
    chk("rst_mid_ctrl", {26'd0, icache_grant, dcache_grant, mem_enable, mem_wr,
                         icache_data_valid, dcache_data_valid}, 32'd0);
    chk("rst_mid_addr", {16'd0, mem_addr}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_stray_seen", {31'd0, (n_mv - s_mv) != 0}, 32'd1);
    chk("rst_stray_ivalid", n_iv - s_iv, 0);
    chk("rst_stray_dvalid", n_dv - s_dv, 0);

    // Fresh fill after reset
    icache_req = 1'b1; icache_addr = 16'h0600; exp_addr = 16'h0600;
    s_rd = n_rd; s_iv = n_iv; s_bd = n_baddata;
    @(negedge clk);
    @(negedge clk);
    chk("post_grant", {31'd0, icache_grant}, 32'd1);
    wait_drop(1'b0, "post_done");
    icache_req = 1'b0;
    tick();
    chk("post_rd_cnt", n_rd - s_rd, 8);
    chk("post_valid_cnt", n_iv - s_iv, 8);
    chk("post_data_bad", n_baddata - s_bd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
